// File: rtl/ex_mem_block.sv
// Execute stage with EX/MEM pipeline register: ALU, branch/jump resolution,
// wrong-path squash after a redirect, and MEM back-pressure handling.
module ex_mem_block #(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] LoadStore32Address,
  input  logic [XLEN-1:0] LoadStoreOrjalAddress,
  input  logic [XLEN-1:0] auipcOrlui,
  input  logic [3:0]      ALUControl,
  input  logic            ALUSourceA,
  input  logic [1:0]      ALUSourceB,
  input  logic [2:0]      BranchType,
  input  logic            JumpReg,
  input  logic [4:0]      rd_in,
  input  logic            IDEXregWrite,
  input  logic            DmemREB,
  input  logic            DmemWEB,
  input  logic            Dmem1ALUOUT,
  input  logic            MEMStall,
  output logic            EXStall,
  output logic            PCsel,
  output logic [XLEN-1:0] JumporBranch,
  output logic [XLEN-1:0] EXMEMALUOUT,
  output logic [XLEN-1:0] EXMEMStoreData,
  output logic [4:0]      EXMEMrd,
  output logic            EXMEMregWrite,
  output logic            EXMEMDmemREB,
  output logic            EXMEMDmemWEB,
  output logic            EXMEMDmem1ALUOUT
);

  localparam int CW = $clog2(FLUSH_DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [XLEN-1:0] op_a, op_b, alu_result, target;
  logic [4:0]     shamt;
  logic           taken, redirect, squash;

  assign EXStall = MEMStall;

  always_comb begin
    op_a = ALUSourceA ? PC : rs1_value;
    case (ALUSourceB)
      2'b00:   op_b = rs2_value;
      2'b01:   op_b = LoadStore32Address;
      2'b10:   op_b = auipcOrlui;
      default: op_b = XLEN'(4);
    endcase
  end

  assign shamt = op_b[4:0];

  always_comb begin
    case (ALUControl)
      4'b0000: alu_result = op_a + op_b;
      4'b0001: alu_result = op_a - op_b;
      4'b0010: alu_result = op_a & op_b;
      4'b0011: alu_result = op_a | op_b;
      4'b0100: alu_result = op_a ^ op_b;
      4'b0101: alu_result = op_a << shamt;
      4'b0110: alu_result = op_a >> shamt;
      4'b0111: alu_result = $signed(op_a) >>> shamt;
      4'b1000: alu_result = XLEN'($signed(op_a) < $signed(op_b));
      4'b1001: alu_result = XLEN'(op_a < op_b);
      4'b1010: alu_result = op_b;
      default: alu_result = '0;
    endcase
  end

  // Branch conditions always look at the raw register operands, not the ALU inputs.
  always_comb begin
    case (BranchType)
      3'b001:  taken = (rs1_value == rs2_value);
      3'b010:  taken = (rs1_value != rs2_value);
      3'b011:  taken = ($signed(rs1_value) <  $signed(rs2_value));
      3'b100:  taken = ($signed(rs1_value) >= $signed(rs2_value));
      3'b101:  taken = (rs1_value <  rs2_value);
      3'b110:  taken = (rs1_value >= rs2_value);
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign target = JumpReg ? ((rs1_value + LoadStore32Address) & {{(XLEN-1){1'b1}}, 1'b0})
                          : (PC + LoadStoreOrjalAddress);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    redirect   = 1'b0;
    squash     = 1'b0;
    if (!MEMStall) begin
      case (state_reg)
        RUN: begin
          if (taken) begin
            redirect   = 1'b1;
            state_next = FLUSH;
            count_next = CW'(FLUSH_DEPTH);
          end
        end
        default: begin
          squash     = 1'b1;
          count_next = count_reg - CW'(1);
          if (count_reg == CW'(1))
            state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg        <= RUN;
      count_reg        <= '0;
      PCsel            <= 1'b0;
      JumporBranch     <= '0;
      EXMEMALUOUT      <= '0;
      EXMEMStoreData   <= '0;
      EXMEMrd          <= '0;
      EXMEMregWrite    <= 1'b0;
      EXMEMDmemREB     <= 1'b1;
      EXMEMDmemWEB     <= 1'b1;
      EXMEMDmem1ALUOUT <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      PCsel     <= redirect;
      if (redirect)
        JumporBranch <= target;
      if (!MEMStall) begin
        if (squash) begin
          EXMEMALUOUT      <= '0;
          EXMEMStoreData   <= '0;
          EXMEMrd          <= '0;
          EXMEMregWrite    <= 1'b0;
          EXMEMDmemREB     <= 1'b1;
          EXMEMDmemWEB     <= 1'b1;
          EXMEMDmem1ALUOUT <= 1'b0;
        end else begin
          EXMEMALUOUT      <= alu_result;
          EXMEMStoreData   <= rs2_value;
          EXMEMrd          <= rd_in;
          EXMEMregWrite    <= IDEXregWrite;
          EXMEMDmemREB     <= DmemREB;
          EXMEMDmemWEB     <= DmemWEB;
          EXMEMDmem1ALUOUT <= Dmem1ALUOUT;
        end
      end
    end
  end

endmodule
